// File: rtl/imm_pkg.sv
// Shared types, tables and helpers for the immediate encoder and decoder.
// Candidate order runs from the narrowest field to the widest; shift 0 comes first.
package imm_pkg;

    typedef enum logic [1:0] {
        NB2  = 2'd0,
        NB4  = 2'd1,
        NB8  = 2'd2,
        NB12 = 2'd3
    } numBits_t;

    localparam logic [3:0] FIELD_WIDTH [4] = '{4'd2, 4'd4, 4'd8, 4'd12};

    localparam int NUM_CAND = 8;

    // Each entry is {numBits, immShift}.
    localparam logic [2:0] CAND_ORDER [NUM_CAND] = '{
        3'b00_0, 3'b00_1,
        3'b01_0, 3'b01_1,
        3'b10_0, 3'b10_1,
        3'b11_0, 3'b11_1
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    function automatic logic fits_signed(
        input logic signed [31:0] value,
        input int                 w
    );
        logic signed [31:0] lim;
        lim = 32'sd1 <<< (w - 1);
        return (value >= -lim) && (value <= lim - 32'sd1);
    endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: sign-extend the selected field width,
// then optionally shift left by one. Mirrors the datapath generator.
module imm_decode
    import imm_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int FIELD_W = 12
) (
    input  logic        [FIELD_W-1:0] din,
    input  numBits_t                  numBits,
    input  logic                      immShift,
    output logic signed [DATA_W-1:0]  value
);

    logic signed [DATA_W-1:0] ext;

    always_comb begin
        ext = '0;
        unique case (numBits)
            NB2:  ext = DATA_W'(signed'(din[1:0]));
            NB4:  ext = DATA_W'(signed'(din[3:0]));
            NB8:  ext = DATA_W'(signed'(din[7:0]));
            NB12: ext = DATA_W'(signed'(din[11:0]));
        endcase
    end

    assign value = immShift ? (ext <<< 1) : ext;

endmodule

// File: rtl/imm_encoder.sv
// Iterative immediate encoder: one candidate encoding is tried per clock.
// Define IMMENC_VERIFY_EN to add a decoder self-check and the err_mismatch port.
module imm_encoder
    import imm_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int FIELD_W = 12
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [DATA_W-1:0]  req_imm,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [FIELD_W-1:0] rsp_din,
    output logic [1:0]         rsp_numbits,
    output logic               rsp_immshift,
    output logic               rsp_fail
`ifdef IMMENC_VERIFY_EN
    ,
    output logic               err_mismatch
`endif
);

    state_t state;
    state_t nextState;
    logic [2:0] idx;
    logic [2:0] nextIdx;
    logic accept;
    logic load;

    logic signed [DATA_W-1:0] immLatched;

    logic [FIELD_W-1:0] rspDin;
    numBits_t rspNb;
    logic rspShift;
    logic rspFail;

    logic [2:0] cand;
    numBits_t candNb;
    logic candShift;
    logic signed [DATA_W-1:0] shifted;
    logic candHit;
    logic [FIELD_W-1:0] candDin;

    assign cand      = CAND_ORDER[idx];
    assign candNb    = numBits_t'(cand[2:1]);
    assign candShift = cand[0];
    assign shifted   = candShift ? (immLatched >>> 1) : immLatched;

    // A shifted candidate only matches even values.
    assign candHit = (!candShift || !immLatched[0])
                   && fits_signed(32'(shifted), int'(FIELD_WIDTH[candNb]));

    always_comb begin
        candDin = '0;
        unique case (candNb)
            NB2:  candDin = FIELD_W'(shifted[1:0]);
            NB4:  candDin = FIELD_W'(shifted[3:0]);
            NB8:  candDin = FIELD_W'(shifted[7:0]);
            NB12: candDin = FIELD_W'(shifted[11:0]);
        endcase
    end

    always_comb begin
        nextState = state;
        nextIdx   = idx;
        accept    = 1'b0;
        load      = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    nextState = SEARCH;
                    nextIdx   = '0;
                    accept    = 1'b1;
                end
            end
            SEARCH: begin
                if (candHit || idx == 3'(NUM_CAND - 1)) begin
                    nextState = DONE;
                    load      = 1'b1;
                end else begin
                    nextIdx = idx + 3'd1;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= nextState;
            idx   <= nextIdx;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            immLatched <= '0;
            rspDin     <= '0;
            rspNb      <= NB2;
            rspShift   <= 1'b0;
            rspFail    <= 1'b0;
        end else begin
            if (accept) begin
                immLatched <= req_imm;
            end
            if (load) begin
                if (candHit) begin
                    rspDin   <= candDin;
                    rspNb    <= candNb;
                    rspShift <= candShift;
                    rspFail  <= 1'b0;
                end else begin
                    rspDin   <= '0;
                    rspNb    <= NB2;
                    rspShift <= 1'b0;
                    rspFail  <= 1'b1;
                end
            end
        end
    end

    assign req_ready    = (state == IDLE);
    assign rsp_valid    = (state == DONE);
    assign rsp_din      = rspDin;
    assign rsp_numbits  = rspNb;
    assign rsp_immshift = rspShift;
    assign rsp_fail     = rspFail;

`ifdef IMMENC_VERIFY_EN
    logic signed [DATA_W-1:0] decoded;
    logic errFlag;

    imm_decode #(
        .DATA_W (DATA_W),
        .FIELD_W(FIELD_W)
    ) u_check (
        .din     (rspDin),
        .numBits (rspNb),
        .immShift(rspShift),
        .value   (decoded)
    );

    // Sticky until reset so a single bad encoding is never lost.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            errFlag <= 1'b0;
        end else if (state == DONE && !rspFail && decoded != immLatched) begin
            errFlag <= 1'b1;
        end
    end

    assign err_mismatch = errFlag;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: latency, encodings, failure,
// backpressure and reset abort.
module tb_imm_encoder;

    logic        CLK;
    logic        RST_N;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_imm;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [11:0] rsp_din;
    logic [1:0]  rsp_numbits;
    logic        rsp_immshift;
    logic        rsp_fail;
`ifdef IMMENC_VERIFY_EN
    logic        err_mismatch;
`endif

    int nCmp = 0;
    int nBad = 0;

    imm_encoder #(
        .DATA_W (16),
        .FIELD_W(12)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_imm     (req_imm),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_din     (rsp_din),
        .rsp_numbits (rsp_numbits),
        .rsp_immshift(rsp_immshift),
        .rsp_fail    (rsp_fail)
`ifdef IMMENC_VERIFY_EN
        ,
        .err_mismatch(err_mismatch)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nBad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic signed [15:0] tbDecode(
        input logic [11:0] d,
        input logic [1:0]  nb,
        input logic        sh
    );
        logic signed [15:0] v;
        case (nb)
            2'd0:    v = {{14{d[1]}}, d[1:0]};
            2'd1:    v = {{12{d[3]}}, d[3:0]};
            2'd2:    v = {{8{d[7]}}, d[7:0]};
            default: v = {{4{d[11]}}, d};
        endcase
        return sh ? (v <<< 1) : v;
    endfunction

    // Accepts at E0, then counts edges until rsp_valid (bounded).
    task automatic runReq(
        input string       tag,
        input logic [15:0] imm,
        input int          expLat,
        input logic [11:0] expDin,
        input logic [1:0]  expNb,
        input logic        expSh,
        input logic        expFail
    );
        int cyc;
        @(negedge CLK);
        req_valid = 1'b1;
        req_imm   = imm;
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        req_imm   = ~imm;
        chk({tag, ".busy"}, {31'b0, req_ready}, 32'd0);
        cyc = 0;
        while (cyc < 20 && !rsp_valid) begin
            @(posedge CLK);
            #1;
            cyc++;
        end
        chk({tag, ".lat"}, cyc, expLat);
        chk({tag, ".din"}, {20'b0, rsp_din}, {20'b0, expDin});
        chk({tag, ".nb"}, {30'b0, rsp_numbits}, {30'b0, expNb});
        chk({tag, ".sh"}, {31'b0, rsp_immshift}, {31'b0, expSh});
        chk({tag, ".fail"}, {31'b0, rsp_fail}, {31'b0, expFail});
    endtask

    task automatic releaseRsp(input string tag);
        @(negedge CLK);
        rsp_ready = 1'b1;
        @(posedge CLK);
        #1;
        rsp_ready = 1'b0;
        chk({tag, ".rvOff"}, {31'b0, rsp_valid}, 32'd0);
        chk({tag, ".rdyOn"}, {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        RST_N     = 1'b0;
        req_valid = 1'b0;
        req_imm   = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        chk("rst.rdy", {31'b0, req_ready}, 32'd1);
        chk("rst.rv", {31'b0, rsp_valid}, 32'd0);
        chk("rst.din", {20'b0, rsp_din}, 32'd0);
        chk("rst.fail", {31'b0, rsp_fail}, 32'd0);

        runReq("m2", 16'hFFFE, 1, 12'h002, 2'd0, 1'b0, 1'b0);
        releaseRsp("m2");

        runReq("zero", 16'h0000, 1, 12'h000, 2'd0, 1'b0, 1'b0);
        releaseRsp("zero");

        runReq("m4", 16'hFFFC, 2, 12'h002, 2'd0, 1'b1, 1'b0);
        releaseRsp("m4");

        runReq("six", 16'd6, 3, 12'h006, 2'd1, 1'b0, 1'b0);
        chk("six.alu", 32'(tbDecode(rsp_din, rsp_numbits, rsp_immshift) + 16'sd2), 32'd8);
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK);
            #1;
            chk("bp.rv", {31'b0, rsp_valid}, 32'd1);
            chk("bp.rdy", {31'b0, req_ready}, 32'd0);
            chk("bp.din", {20'b0, rsp_din}, 32'h006);
            chk("bp.nb", {30'b0, rsp_numbits}, 32'd1);
        end
        releaseRsp("six");

        runReq("h100", 16'd100, 5, 12'h064, 2'd2, 1'b0, 1'b0);
        releaseRsp("h100");

        runReq("b4094", 16'd4094, 8, 12'h7FF, 2'd3, 1'b1, 1'b0);
        releaseRsp("b4094");

        runReq("max", 16'h7FFF, 8, 12'h000, 2'd0, 1'b0, 1'b1);
        releaseRsp("max");

        runReq("minneg", 16'h8000, 8, 12'h000, 2'd0, 1'b0, 1'b1);
        releaseRsp("minneg");

        runReq("m2048", 16'hF800, 7, 12'h800, 2'd3, 1'b0, 1'b0);
        releaseRsp("m2048");

`ifdef IMMENC_VERIFY_EN
        chk("verify.err", {31'b0, err_mismatch}, 32'd0);
`endif

        // Abort a failing search while candidate 3 is being evaluated.
        @(negedge CLK);
        req_valid = 1'b1;
        req_imm   = 16'h7FFF;
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RST_N = 1'b0;
        #1;
        chk("abort.rv", {31'b0, rsp_valid}, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        chk("abort.rdy", {31'b0, req_ready}, 32'd1);
        chk("abort.fail", {31'b0, rsp_fail}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            @(posedge CLK);
            #1;
            chk("abort.stale", {31'b0, rsp_valid}, 32'd0);
        end

        runReq("post", 16'hFFFE, 1, 12'h002, 2'd0, 1'b0, 1'b0);
        releaseRsp("post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Iterative immediate encoder; the inverse of the datapath immediate generator.
- Takes a 16-bit signed target value and searches for the most compact (din, numBits, immShift) triple that the immediate generator decodes back to exactly that value.
- Sits in the instruction-assembly/loader path ahead of instruction memory. Valid/ready request and response channels; one candidate encoding is evaluated per clock.

Parameters:
- DATA_W, 16, width of the target immediate and of the decoded value.
- FIELD_W, 12, width of the din field; must be at least the largest field width in the package table.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  encoder can accept a request.
- req_imm  input  DATA_W  signed target immediate.
- rsp_valid  output  1  result present.
- rsp_ready  input  1  consumer accepts the result.
- rsp_din  output  FIELD_W  encoded field; upper unused bits are zero.
- rsp_numbits  output  2  field-width code.
- rsp_immshift  output  1  1 = decoded value is the field shifted left by 1.
- rsp_fail  output  1  no encoding exists; din, numBits and immShift outputs are all zero.
- err_mismatch  output  1  self-check flag; only exists when the optional feature is compiled in.

Behaviour:
- Clock and reset: one clock CLK; reset is asynchronous and active-low (RST_N).
- Field-width code (numBits): 0 = 2 bits, 1 = 4 bits, 2 = 8 bits, 3 = 12 bits.
- Decode rule: decoded = sign_extend(din[w-1:0]) << immShift, computed at DATA_W bits.
- Candidate order, idx 0..7: (nb0,s0), (nb0,s1), (nb1,s0), (nb1,s1), (nb2,s0), (nb2,s1), (nb3,s0), (nb3,s1). Smallest width wins; at equal width, shift 0 wins.
- Candidate hit:
  - s0: imm lies in [-2^(w-1), 2^(w-1)-1].
  - s1: imm[0]==0 and (imm>>>1) lies in the same range.
  - On a hit, din = the low w bits of the (shifted) value; all other bits are zero.
- FSM states: IDLE, SEARCH, DONE.
  - IDLE: req_ready=1. On req_valid, latch req_imm, idx:=0, go to SEARCH.
  - SEARCH: req_ready=0; evaluate candidate idx each cycle.
    - Hit: register the result, go to DONE.
    - Miss with idx==7: register rsp_fail=1 and zero fields, go to DONE.
    - Otherwise idx:=idx+1.
  - DONE: rsp_valid=1, outputs held stable. On rsp_ready, go to IDLE; req_ready rises the following cycle. No same-cycle re-accept.
- Latency: request accepted at edge E0; candidate k is evaluated between E_k and E_(k+1); rsp_valid is high after E_(k+1). Fail responses appear after E8.
- Backpressure: DONE holds indefinitely while rsp_ready=0. req_imm changes after acceptance have no effect.
- Reset values: state=IDLE, idx=0, req_ready=1 once reset is released, rsp_valid=0, all rsp_* fields 0, err_mismatch=0.
- Reset asserted mid-SEARCH or mid-DONE: immediate return to reset values. No response is produced for the aborted request.
- Zero input: imm=0 hits at idx0 with din=0, nb0, s0.
- Most-negative input: imm=-32768 must fail; it is not representable.

Optional Feature:
- Macro: IMMENC_VERIFY_EN.
- With the macro: an imm_decode instance reconstructs the value from the registered result. In DONE, with rsp_fail=0, err_mismatch is set when the reconstruction differs from the latched imm. The flag is sticky until reset.
- Without the macro: no decoder is instantiated and the err_mismatch port is absent.

Decomposition:
- Shared package imm_pkg:
  - numBits code typedef.
  - FIELD_WIDTH lookup constant: 2, 4, 8, 12.
  - Candidate-order constant table.
  - FSM state enum.
  - Helper function fits_signed(value, w).
- Sub-module imm_decode: combinational din/numBits/immShift to DATA_W signed value.
  - Reused by the optional self-check.
  - Matches the datapath immediate generator bit-for-bit.

Test Plan:
- req_imm=-2 -> rsp after E1; din=0x002, nb=0, shift=0, fail=0.
- req_imm=6 -> rsp after E3; din=0x006, nb=1, shift=0. Decoding it yields 6; with A=2 the ALU add gives 8.
- req_imm=-4 -> rsp after E2; din=0x002, nb=0, shift=1. req_imm=100 -> rsp after E5; din=0x064, nb=2, shift=0.
- req_imm=4094 -> rsp after E8; din=0x7FF, nb=3, shift=1. req_imm=0x7FFF -> rsp after E8; fail=1, all fields 0.
- Backpressure: hold rsp_ready=0 for 10 cycles -> outputs stable and req_ready=0. Then pulse rsp_ready -> IDLE, with req_ready=1 the next cycle.
- Reset: assert RST_N=0 at idx3 of the 0x7FFF search -> rsp_valid=0, req_ready=1 after release, no stale response. With IMMENC_VERIFY_EN, the other scenarios leave err_mismatch=0.
